// File: rtl/dzcpu_uop_sequencer.sv
// Micro-program sequencer for the dzcpu core: owns the micro-PC, loads LUT flow indices,
// steps and terminates microcode flows, and injects the interrupt-entry flow between instructions.
module dzcpu_uop_sequencer #(
  parameter int                 UPC_W        = 8,
  parameter logic [UPC_W-1:0]   INT_FLOW_IDX = UPC_W'(175)
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic [UPC_W-1:0] iFlowIdx,
  input  logic [3:0]       iUopCtl,
  input  logic             iZ,
  input  logic             iStall,
  input  logic             iIme,
  input  logic [4:0]       iIntReq,
  input  logic [4:0]       iIntEn,
  output logic [UPC_W-1:0] oUopAddr,
  output logic             oLutSel,
  output logic             oPcInc,
  output logic             oFlagUpd,
  output logic             oInstrDone,
  output logic [4:0]       oIntAck,
  output logic [7:0]       oIntVector,
  output logic             oFault
);

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_INT} state_e;

  state_e           state_q, state_d;
  logic [UPC_W-1:0] upc_q, upc_d;
  logic             sel_q, sel_d;
  logic [7:0]       vec_q, vec_d;
  logic             fault_q, fault_d;
  logic [4:0]       pend_q, pend_d;

  logic             pc_inc, flag_upd, instr_done;
  logic [4:0]       int_ack;
  logic             eof, step;
  logic [2:0]       int_n;
  logic [4:0]       int_hit;

  assign int_hit = iIntReq & iIntEn;

  // Priority encode the request mask captured at end-of-flow: lowest bit wins.
  always_comb begin
    int_n = 3'd0;
    for (int i = 4; i >= 0; i--)
      if (pend_q[i]) int_n = 3'(i);
  end

  always_comb begin
    state_d    = state_q;
    upc_d      = upc_q;
    sel_d      = sel_q;
    vec_d      = vec_q;
    fault_d    = fault_q;
    pend_d     = pend_q;
    pc_inc     = 1'b0;
    flag_upd   = 1'b0;
    instr_done = 1'b0;
    int_ack    = 5'd0;
    eof        = 1'b0;
    step       = 1'b0;

    if (!iStall) begin
      unique case (state_q)
        S_IDLE: state_d = S_DECODE;
        S_DECODE: begin
          upc_d   = iFlowIdx;
          state_d = S_EXEC;
        end
        S_EXEC: begin
          unique case (iUopCtl)
            4'd0: step = 1'b1;
            4'd1: begin pc_inc = 1'b1; step = 1'b1; end
            4'd2: eof = 1'b1;
            4'd3: begin pc_inc = 1'b1; eof = 1'b1; end
            4'd4: begin flag_upd = 1'b1; eof = 1'b1; end
            4'd5: begin pc_inc = 1'b1; flag_upd = 1'b1; eof = 1'b1; end
            4'd6: begin pc_inc = 1'b1; eof = iZ;  step = !iZ; end
            4'd7: begin pc_inc = 1'b1; eof = !iZ; step = iZ;  end
            4'd8: begin
              pc_inc  = 1'b1;
              sel_d   = 1'b1;
              state_d = S_DECODE;
            end
            4'd9: begin flag_upd = 1'b1; step = 1'b1; end
            default: begin step = 1'b1; fault_d = 1'b1; end
          endcase
          if (step) begin
            upc_d = upc_q + 1'b1;
            if (&upc_q) fault_d = 1'b1;
          end
          // Interrupts are only considered here, so a request must still be up on the end cycle.
          if (eof) begin
            instr_done = 1'b1;
            sel_d      = 1'b0;
            pend_d     = int_hit;
            state_d    = (iIme && |int_hit) ? S_INT : S_DECODE;
          end
        end
        S_INT: begin
          int_ack = pend_q & (~pend_q + 5'd1);
          vec_d   = 8'h40 + {2'b00, int_n, 3'b000};
          upc_d   = INT_FLOW_IDX;
          state_d = S_EXEC;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state_q <= S_IDLE;
      upc_q   <= '0;
      sel_q   <= 1'b0;
      vec_q   <= 8'd0;
      fault_q <= 1'b0;
      pend_q  <= 5'd0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      sel_q   <= sel_d;
      vec_q   <= vec_d;
      fault_q <= fault_d;
      pend_q  <= pend_d;
    end
  end

  assign oUopAddr   = upc_q;
  assign oLutSel    = sel_q;
  assign oPcInc     = pc_inc;
  assign oFlagUpd   = flag_upd;
  assign oInstrDone = instr_done;
  assign oIntAck    = int_ack;
  assign oIntVector = vec_q;
  assign oFault     = fault_q;

endmodule
